// File: rtl/line_clear_sequencer.sv
// line_clear_sequencer: removes full rows from the board store after a piece locks and owns the board cell port.
// Define LINE_CLEAR_SCORE_EN to add a saturating 16-bit score output.
module line_clear_sequencer #(
  parameter int BOARD_HEIGHT = 20,
  parameter int BOARD_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [4:0]              eng_i,
  input  logic [4:0]              eng_j,
  input  logic                    eng_we,
  input  logic [2:0]              eng_wdata,
  output logic [2:0]              eng_rdata,
  output logic [4:0]              brd_i,
  output logic [4:0]              brd_j,
  output logic                    brd_we,
  output logic [2:0]              brd_wdata,
  input  logic [2:0]              brd_rdata,
  input  logic [BOARD_HEIGHT-1:0] line_full,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              lines_cleared
`ifdef LINE_CLEAR_SCORE_EN
  ,
  output logic [15:0]             score
`endif
);
  typedef enum logic [2:0] {IDLE, SCAN, READ, WRITE, FILL, DONE} state_t;
  localparam logic [4:0] LAST_J = 5'(BOARD_WIDTH - 1);
  state_t     r_state;
  logic [4:0] r_i, r_j, w_top;
  logic [2:0] r_hold, r_n;
  always_comb begin
    w_top = '0;
    for (int k = 0; k < BOARD_HEIGHT; k++) if (line_full[k]) w_top = 5'(k);
  end
  // READ fetches the cell above the row being overwritten; WRITE stores it one row lower.
  always_comb begin
    brd_i     = r_state == IDLE ? eng_i : r_state == READ ? r_i - 5'd1 : r_state == WRITE ? r_i : 5'd0;
    brd_j     = r_state == IDLE ? eng_j : (r_state == READ || r_state == WRITE || r_state == FILL) ? r_j : 5'd0;
    brd_we    = r_state == IDLE ? eng_we : (r_state == WRITE || r_state == FILL);
    brd_wdata = r_state == IDLE ? eng_wdata : r_state == WRITE ? r_hold : 3'd0;
    eng_rdata = r_state == IDLE ? brd_rdata : 3'd0;
  end
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
`ifdef LINE_CLEAR_SCORE_EN
  logic [10:0] w_pts;
  logic [16:0] w_sum;
  assign w_pts = r_n == 3'd0 ? 11'd0 : r_n == 3'd1 ? 11'd40 : r_n == 3'd2 ? 11'd100 : r_n == 3'd3 ? 11'd300 : 11'd1200;
  assign w_sum = {1'b0, score} + {6'd0, w_pts};
  always_ff @(posedge clk) begin
    if (reset) score <= '0;
    else if (r_state == SCAN && line_full == '0) score <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
  end
`endif
  // lines_cleared is loaded on entry to DONE so it is already valid while done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_i           <= '0;
      r_j           <= '0;
      r_hold        <= '0;
      r_n           <= '0;
      lines_cleared <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_n     <= '0;
          r_state <= SCAN;
        end
        SCAN: if (line_full == '0) begin
          lines_cleared <= r_n;
          r_state       <= DONE;
        end else begin
          r_i     <= w_top;
          r_j     <= '0;
          r_state <= w_top == 5'd0 ? FILL : READ;
        end
        READ: begin
          r_hold  <= brd_rdata;
          r_state <= WRITE;
        end
        WRITE: if (r_j < LAST_J) begin
          r_j     <= r_j + 5'd1;
          r_state <= READ;
        end else begin
          r_j     <= '0;
          r_i     <= r_i == 5'd1 ? r_i : r_i - 5'd1;
          r_state <= r_i == 5'd1 ? FILL : READ;
        end
        FILL: if (r_j < LAST_J) r_j <= r_j + 5'd1;
        else begin
          r_j     <= '0;
          r_n     <= r_n == 3'd7 ? r_n : r_n + 3'd1;
          r_state <= SCAN;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_clear_sequencer.sv
// tb_line_clear_sequencer: scoreboard bench with a board-store model and a row-compaction reference model.
module tb_line_clear_sequencer;
  localparam int H = 20, W = 10;
  logic clk = 0, reset = 1, start = 0;
  logic [4:0] eng_i = 0, eng_j = 0;
  logic eng_we = 0;
  logic [2:0] eng_wdata = 0;
  logic [2:0] eng_rdata, brd_wdata, brd_rdata, lines_cleared;
  logic [4:0] brd_i, brd_j;
  logic brd_we, busy, done;
  logic [H-1:0] line_full;
  logic [2:0] mem [H][W];
  logic [2:0] want [H][W];
  logic [2:0] exp_brd [H][W];
  int total = 0, bad = 0, cyc = 0, wr_cnt = 0;
  int q_n[$], q_cyc[$], q_wr[$];
`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] score;
  int exp_score = 0;
  int q_sc[$];
`endif

  line_clear_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .eng_i(eng_i), .eng_j(eng_j), .eng_we(eng_we), .eng_wdata(eng_wdata), .eng_rdata(eng_rdata),
    .brd_i(brd_i), .brd_j(brd_j), .brd_we(brd_we), .brd_wdata(brd_wdata), .brd_rdata(brd_rdata),
    .line_full(line_full), .busy(busy), .done(done), .lines_cleared(lines_cleared)
`ifdef LINE_CLEAR_SCORE_EN
    , .score(score)
`endif
  );

  always #5 clk = ~clk;

  // board store: sync write, combinational read, full flags derived from stored cells
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) mem[r][c] <= 3'd0;
    end else if (brd_we && brd_i < 5'd20 && brd_j < 5'd10) mem[brd_i][brd_j] <= brd_wdata;
  end
  assign brd_rdata = (brd_i < 5'd20 && brd_j < 5'd10) ? mem[brd_i][brd_j] : 3'd0;
  always_comb
    for (int r = 0; r < H; r++) begin
      line_full[r] = 1'b1;
      for (int c = 0; c < W; c++) if (mem[r][c] == 3'd0) line_full[r] = 1'b0;
    end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // monitor: pops an expectation whenever done is presented
  always @(negedge clk) begin
    int e;
    if (!reset) begin
      if (busy && brd_we) wr_cnt++;
      if (done) begin
        if (q_n.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          chk("lines_cleared", int'(lines_cleared), q_n.pop_front());
          chk("done_cycle", cyc, q_cyc.pop_front());
          chk("board_writes", wr_cnt, q_wr.pop_front());
`ifdef LINE_CLEAR_SCORE_EN
          chk("score", int'(score), q_sc.pop_front());
`endif
          e = 0;
          for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) if (mem[r][c] !== exp_brd[r][c]) e++;
          chk("board_cells_wrong", e, 0);
        end
        wr_cnt = 0;
      end
    end
  end

  // reference: full rows vanish, survivors drop to the bottom in order, top refilled with zeros
  task automatic model(output int n, output int lat, output int wr);
    int dst;
    bit full;
    n = 0; lat = 2; wr = 0; dst = H - 1;
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) exp_brd[r][c] = 3'd0;
    for (int r = H - 1; r >= 0; r--) begin
      full = 1;
      for (int c = 0; c < W; c++) if (want[r][c] == 3'd0) full = 0;
      if (full) begin
        lat += 2 * W * (r + n) + W + 1;
        wr  += W * (r + n) + W;
        n++;
      end else begin
        for (int c = 0; c < W; c++) exp_brd[dst][c] = want[r][c];
        dst--;
      end
    end
  endtask

  task automatic run_op(input bit lock, input bit gate);
    int n, lat, wr;
    model(n, lat, wr);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) begin
      @(negedge clk);
      eng_i = 5'(r); eng_j = 5'(c); eng_we = 1; eng_wdata = want[r][c];
      if (lock && r == H - 1 && c == W - 1) start = 1;
    end
    if (!lock) begin
      @(negedge clk);
      eng_we = 0; eng_i = 5'd18; eng_j = 5'd3;
      #1 chk("passthru_rdata", int'(eng_rdata), int'(want[18][3]));
      start = 1;
    end
    q_n.push_back(n > 7 ? 7 : n);
    q_cyc.push_back(cyc + lat);
    q_wr.push_back(wr);
`ifdef LINE_CLEAR_SCORE_EN
    exp_score += n == 0 ? 0 : n == 1 ? 40 : n == 2 ? 100 : n == 3 ? 300 : 1200;
    if (exp_score > 65535) exp_score = 65535;
    q_sc.push_back(exp_score);
`endif
    @(negedge clk);
    start = 0; eng_we = 0;
    if (gate) begin
      repeat (4) @(negedge clk);
      eng_we = 1; eng_i = 5'd0; eng_j = 5'd0; eng_wdata = 3'd7; start = 1;
      #1 chk("busy_rdata", int'(eng_rdata), 0);
      chk("busy_flag", int'(busy), 1);
      @(negedge clk);
      eng_we = 0; start = 0;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (q_n.size() != 0 && t < 10000) begin
      @(negedge clk);
      t++;
    end
    if (q_n.size() != 0) begin
      chk("timeout_waiting_done", 0, 1);
      q_n.delete(); q_cyc.delete(); q_wr.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_want();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) want[r][c] = 3'd0;
  endtask

  task automatic fill_row(input int r);
    for (int c = 0; c < W; c++) want[r][c] = 3'(1 + c % 7);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_lines", int'(lines_cleared), 0);
    chk("reset_brd_we", int'(brd_we), 0);
    reset = 0;
    @(negedge clk);
    clear_want(); run_op(0, 0); wait_idle();
    clear_want(); fill_row(19); want[18][3] = 3'd5; run_op(0, 0); wait_idle();
    chk("row19_col3", int'(mem[19][3]), 5);
    chk("row18_col3", int'(mem[18][3]), 0);
    clear_want(); for (int r = 16; r < 20; r++) fill_row(r); run_op(0, 0); wait_idle();
    clear_want(); fill_row(10); fill_row(19); want[9][4] = 3'd6; run_op(0, 0); wait_idle();
    chk("marker_row11", int'(mem[11][4]), 6);
    clear_want(); fill_row(19); want[5][2] = 3'd3; run_op(0, 1); wait_idle();
    chk("gated_write_dropped", int'(mem[0][0]), 0);
    clear_want(); fill_row(19); want[17][0] = 3'd2; run_op(1, 0); wait_idle();
    repeat (8) begin
      for (int r = 0; r < H; r++) begin
        bit full;
        full = $urandom_range(0, 3) == 0;
        for (int c = 0; c < W; c++) want[r][c] = full ? 3'($urandom_range(1, 7)) : 3'($urandom_range(0, 7));
        if (!full) want[r][$urandom_range(0, W - 1)] = 3'd0;
      end
      run_op(1'($urandom_range(0, 1)), 0);
      wait_idle();
    end
    clear_want(); fill_row(19); want[3][3] = 3'd4; run_op(0, 0);
    repeat (50) @(negedge clk);
    reset = 1;
    q_n.delete(); q_cyc.delete(); q_wr.delete();
`ifdef LINE_CLEAR_SCORE_EN
    q_sc.delete(); exp_score = 0;
`endif
    @(negedge clk);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_lines", int'(lines_cleared), 0);
    chk("midreset_line_full", int'(line_full), 0);
`ifdef LINE_CLEAR_SCORE_EN
    chk("midreset_score", int'(score), 0);
`endif
    reset = 0;
    repeat (3) @(negedge clk);
    chk("final_done_low", int'(done), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/line_clear_sequencer.md
# line_clear_sequencer

Sequences row removal on the 20×10 board store once a piece has locked. It owns the board's single cell-access port (address, write enable, write data, combinational read data) and arbitrates it with the game engine. While idle it passes engine accesses through. On `start` it repeatedly finds the bottom-most full row and shifts every row above it down by one. It then blanks row 0 and reports how many lines were removed.

## Interface
- `BOARD_HEIGHT`, 20: number of rows; row 0 is the top row.
- `BOARD_WIDTH`, 10: number of columns.
- `clk`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `start`  in  1  single-cycle pulse from the engine after a piece locks; sampled only in IDLE.
- `eng_i`, `eng_j`  in  5 each  engine cell address.
- `eng_we`  in  1  engine write enable.
- `eng_wdata`  in  3  engine write data.
- `eng_rdata`  out  3  engine read data.
- `brd_i`, `brd_j`  out  5 each  board cell address.
- `brd_we`  out  1  board write enable.
- `brd_wdata`  out  3  board write data.
- `brd_rdata`  in  3  board combinational read data.
- `line_full`  in  `BOARD_HEIGHT`  full flag per row; bit k corresponds to row k.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a clear operation.
- `lines_cleared`  out  3  rows removed by the last operation; held until the next `start`.

## Operation
- **States:** IDLE, SCAN, READ, WRITE, FILL, DONE. Registers: row `i`, column `j`, 3-bit `hold`, count `n`.
- **IDLE:**
  - Port passthrough: `brd_*` = `eng_*` and `eng_rdata` = `brd_rdata`.
  - On `start`: `n`←0, go to SCAN.
- **SCAN:**
  - If `line_full`==0, go to DONE.
  - Otherwise let r = the highest set index, set `i`←r and `j`←0.
  - Go to FILL if r==0, else go to READ.
- **READ:** address (`i`−1, `j`), `brd_we`=0, `hold`←`brd_rdata`. Go to WRITE.
- **WRITE:**
  - Address (`i`, `j`), `brd_we`=1, `brd_wdata`=`hold`.
  - If `j`<W−1: `j`++, go to READ.
  - Else `j`←0. If `i`==1, go to FILL; otherwise `i`−−, go to READ.
- **FILL:**
  - Address (0, `j`), `brd_we`=1, `brd_wdata`=3'd0 (null piece).
  - If `j`<W−1: `j`++.
  - Else `n`++ and go to SCAN.
- **DONE:**
  - `done`=1, `lines_cleared`←`n` (saturating at 7).
  - Go to IDLE.
- **Port while busy:** `eng_rdata`=3'd0 and engine writes are dropped; the engine must hold off until `busy` falls.
- **Addresses in SCAN/DONE:** driven with `brd_we`=0 and address (0,0).
- **Arithmetic:** `i` and `j` are 5-bit and never leave the range 0..H−1 and 0..W−1 respectively.

## Timing
- **Reset values:** state IDLE, `busy`=0, `done`=0, `lines_cleared`=0, `brd_we`=0, `i`=`j`=`n`=0, `hold`=0.
- **Reset mid-operation:** abandons the shift immediately. The board store shares `reset`, so no partial state survives.
- **Start acceptance:** `start` registers at the edge; `busy` rises the cycle after `start`.
- **Same-cycle lock and start:** an engine write in the same cycle as `start` still passes through, and SCAN sees the resulting `line_full`.
- **Full-flag latency:** `line_full` reflects a write one cycle after it. SCAN therefore always follows the last FILL cycle, so the flags it sees are already updated.
- **Cost per removed row r:** 2·W·r + W + 1 cycles. Worst case for one row (r=19) is 391 cycles.
- **Total latency:** `start`→`done` = 1 (SCAN) + Σ(per-row cost) + 1 (DONE). An operation with no full row gives `done` 2 cycles after `start`.
- **`start` while busy:** ignored and not queued.

## Configuration
- **`LINE_CLEAR_SCORE_EN` defined:**
  - Adds output `score` (16 bits, reset 0).
  - In DONE, `score` adds 40, 100, 300 or 1200 for `n`=1, 2, 3, ≥4 respectively, and nothing for 0.
  - The sum saturates at 65535.
- **`LINE_CLEAR_SCORE_EN` undefined:** no `score` port and no adder.

## Test plan
- **No full row:** `line_full`=0 and `start` → `done` 2 cycles later, `lines_cleared`=0, no `brd_we` pulses.
- **Bottom row cleared:** row 19 full, row 18 holding one cell of value 5 at column 3, `start` →
  - after 391+2 cycles, row 19 col 3 = 5 and the rest of row 19 is 0;
  - rows 0 and 18 are all 0;
  - `lines_cleared`=1.
- **Four rows cleared:** rows 16–19 full, rows 0–15 empty → `lines_cleared`=4, board all 0. With the macro, `score`=1200.
- **Non-adjacent rows:** rows 10 and 19 full, row 9 has a marker cell → `lines_cleared`=2 and the marker ends at row 11.
- **Busy gating:**
  - Engine write during busy leaves the board unchanged and `eng_rdata` reads 0.
  - A second `start` during busy produces no second `done`.
- **Reset mid-operation:** reset 50 cycles into a clear → next cycle `busy`=0, `lines_cleared`=0, and all `line_full` bits read 0.
